regfile_wb_arbiter: RTL

- Write-side front end for the 32x32 register file's single write port.
- Merges the in-order pipeline writeback (port A, never stalled) with a long-latency result source such as the divider (port B, valid/ready).
- Buffers B results in a small FIFO while A holds the port, kills buffered writes made stale by younger A writes, and reports pending writes to the decode stage so it can stall.

---
 rtl/regfile_wb_arbiter_if.sv | 40 ++++
 rtl/regfile_wb_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Write-side bus bundle for the register file write arbiter.
// Groups the pipeline writeback (A), the long-latency result source (B),
// the decode-stage hazard query and the register file write port.
//   master : drives A/B requests and query addresses, observes the rest
//   slave  : the arbiter itself
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              a_we;
  logic [ADDR_W-1:0] a_waddr;
  logic [DATA_W-1:0] a_wdata;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_waddr;
  logic [DATA_W-1:0] b_wdata;
  logic [ADDR_W-1:0] q_addr1;
  logic [ADDR_W-1:0] q_addr2;
  logic              q_hit1;
  logic              q_hit2;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  modport master (
    output a_we, a_waddr, a_wdata,
    output b_valid, b_waddr, b_wdata,
    output q_addr1, q_addr2,
    input  b_ready, q_hit1, q_hit2,
    input  we, waddr, wdata
  );

  modport slave (
    input  a_we, a_waddr, a_wdata,
    input  b_valid, b_waddr, b_wdata,
    input  q_addr1, q_addr2,
    output b_ready, q_hit1, q_hit2,
    output we, waddr, wdata
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter.
// Merges the never-stalled pipeline writeback (A) with a valid/ready
// long-latency source (B). B results that cannot be written immediately are
// held in a DEPTH-entry FIFO; buffered entries made stale by a younger A write
// to the same register are killed and dropped when they reach the head.
// Decode can query whether a live buffered write targets its operands.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - regfile_wb_arbiter_if.slave (A/B requests, hazard query, write port)
module regfile_wb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic clk,
  input  logic rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  live_q, live_d;
  logic [PTR_W-1:0]  rd_q, wr_q;
  logic [CNT_W-1:0]  count_q;

  logic              b_ready_c;
  logic              hs;
  logic              pop;
  logic              push;
  logic              bypass;
  logic              we_c;
  logic [ADDR_W-1:0] waddr_c;
  logic [DATA_W-1:0] wdata_c;
  logic              hit1_c, hit2_c;

  // Write port selection, FIFO control and kill: all combinational.
  always_comb begin
    live_d  = live_q;
    pop     = 1'b0;
    bypass  = 1'b0;
    we_c    = 1'b0;
    waddr_c = '0;
    wdata_c = '0;

    // Registered count only, so a pop while full frees the slot next cycle.
    b_ready_c = !rst && (count_q < CNT_W'(DEPTH));
    hs        = bus.b_valid && b_ready_c;

    if (!rst) begin
      if (bus.a_we) begin
        we_c    = 1'b1;
        waddr_c = bus.a_waddr;
        wdata_c = bus.a_wdata;
      end else if (count_q != '0) begin
        // A killed head is popped silently to keep B writes in order.
        pop = 1'b1;
        if (live_q[rd_q]) begin
          we_c    = 1'b1;
          waddr_c = addr_q[rd_q];
          wdata_c = data_q[rd_q];
        end
      end else if (hs && (bus.b_waddr != '0)) begin
        bypass  = 1'b1;
        we_c    = 1'b1;
        waddr_c = bus.b_waddr;
        wdata_c = bus.b_wdata;
      end
    end

    // Writes to r0 are consumed by the handshake but never stored.
    push = hs && !bypass && (bus.b_waddr != '0);

    // Kill only looks at entries present at the start of the cycle; the
    // push below is applied afterwards so a same-cycle B entry stays live.
    if (!rst && bus.a_we && (bus.a_waddr != '0)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_q[i] == bus.a_waddr) live_d[i] = 1'b0;
      end
    end
    if (pop)  live_d[rd_q] = 1'b0;
    if (push) live_d[wr_q] = 1'b1;
  end

  // Hazard query from registered FIFO state only; free slots have live=0.
  always_comb begin
    hit1_c = 1'b0;
    hit2_c = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (addr_q[i] == bus.q_addr1)) hit1_c = 1'b1;
      if (live_q[i] && (addr_q[i] == bus.q_addr2)) hit2_c = 1'b1;
    end
    hit1_c = hit1_c && !rst && (bus.q_addr1 != '0);
    hit2_c = hit2_c && !rst && (bus.q_addr2 != '0);
  end

  assign bus.b_ready = b_ready_c;
  assign bus.we      = we_c;
  assign bus.waddr   = waddr_c;
  assign bus.wdata   = wdata_c;
  assign bus.q_hit1  = hit1_c;
  assign bus.q_hit2  = hit2_c;

  // FIFO control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      live_q  <= '0;
    end else begin
      live_q  <= live_d;
      if (pop)  rd_q <= rd_q + PTR_W'(1);
      if (push) wr_q <= wr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO payload; validity is tracked by live_q, so no reset needed here.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_q] <= bus.b_waddr;
      data_q[wr_q] <= bus.b_wdata;
    end
  end

endmodule
